id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
// - ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
// - Captures the ID-stage decoder control bundle, operands and register indices, and presents them to EX one cycle later.
// - On a load-use hazard it stalls PC and IF/ID and inserts a bubble.
// - On a branch/jump flush from a later stage it squashes the captured instruction.
// - Keeps a saturating count of inserted stall bubbles for performance debug.
// PARAMETERS
// - DATA_W      32  width of PC, operand and immediate paths
// - REG_ADDR_W  5   register-index width
// - CNT_W       16  width of stall-bubble counter
// PORTS
// - clk_i          in   1           clock, rising edge
// - rst_i          in   1           reset, asynchronous, active-high
// - flush_i        in   1           squash the instruction entering EX (branch taken / jump)
// - id_ctrl_i      in   16          {ALUOp[2],ALUSrc,Branch,BranchType[2],Jump[2],MemToReg[2],MemRead,MemWrite,RegWrite,RegDst[2]}
// - id_pc4_i       in   DATA_W      PC+4 of the ID instruction
// - id_rs_data_i   in   DATA_W      register-file read data for rs
// - id_rt_data_i   in   DATA_W      register-file read data for rt
// - id_imm_i       in   DATA_W      sign-extended immediate
// - id_rs_i        in   REG_ADDR_W  rs index
// - id_rt_i        in   REG_ADDR_W  rt index
// - id_rd_i        in   REG_ADDR_W  rd index
// - id_funct_i     in   6           function field
// - ex_ctrl_o      out  16          registered control bundle (same packing as id_ctrl_i)
// - ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o   out  DATA_W      registered copies
// - ex_rs_o, ex_rt_o, ex_rd_o                         out  REG_ADDR_W  registered copies
// - ex_funct_o     out  6           registered funct
// - ex_valid_o     out  1           1 = EX holds a real instruction, 0 = bubble
// - pc_write_o     out  1           0 = hold PC this cycle
// - if_id_write_o  out  1           0 = hold IF/ID this cycle
// - stall_cnt_o    out  CNT_W       bubbles inserted since reset, saturating
// BEHAVIOUR
// - Reset (async, rst_i=1):
//   - all ex_* outputs, ex_valid_o and stall_cnt_o go to 0.
//   - pc_write_o and if_id_write_o are combinational and read 1 while in reset.
// - Hazard (combinational):
//   - hazard = ex_valid_o & ex_ctrl_o.MemRead & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i)).
// - Stall outputs: pc_write_o = if_id_write_o = ~(hazard & ~flush_i).
// - Register update, every rising edge, in priority order:
//   1. flush_i = 1: ex_ctrl_o <= 0, ex_valid_o <= 0. Data fields are don't-care but held. stall_cnt_o is unchanged. Flush beats hazard.
//   2. hazard = 1: bubble. ex_ctrl_o <= 0, ex_valid_o <= 0, stall_cnt_o += 1. The ID instruction is re-presented next cycle because IF/ID holds.
//   3. Otherwise: all ex_* outputs take their id_* inputs and ex_valid_o <= 1.
// - Latency: 1 cycle from ID inputs to EX outputs.
// - A load-use pair costs exactly 1 bubble. Back-to-back loads feeding each other stall once per dependent pair.
// - A bubble has RegWrite=0, MemWrite=0, MemRead=0 and Branch=0, so it cannot alter architectural state.
// - Counter saturates at 2^CNT_W-1 and never wraps.
// - Reset asserted mid-stall:
//   - stall is dropped immediately and outputs return to reset values.
//   - After reset release, the first edge captures ID normally.
// STRUCTURE
// - Shared package pipe_pkg:
//   - CTRL_W=16 and the bit-field offsets of the control bundle;
//   - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_SLTI;
//   - FUNCT_JR.
// - One sub-module, hazard_detect_unit: purely combinational hazard/stall logic. Ports: ex_valid, ex_memread, ex_rt, id_rs, id_rt, flush; outputs hazard, pc_write, if_id_write.
// - The register bank and the counter live in id_ex_stage.
// TESTING
// 1. No hazard: "add $3,$1,$2" in ID, EX idle -> next edge ex_rd_o=3, ex_valid_o=1, RegWrite=1; pc_write_o stays 1.
// 2. Load-use: "lw $5,0($1)" in EX, "add $6,$5,$2" in ID
//    -> pc_write_o=if_id_write_o=0 for 1 cycle; next edge ex_valid_o=0, ex_ctrl_o=0, stall_cnt_o=1.
//    -> On the following edge the add enters EX with ex_rs_o=5.
// 3. Load to $0: "lw $0,0($1)" in EX, ID reads $0 -> no stall, stall_cnt_o unchanged.
// 4. Flush and hazard in the same cycle -> pc_write_o=1, ex_valid_o=0 next edge, stall_cnt_o unchanged.
// 5. Reset pulse while hazard is active -> all ex_* outputs are 0 asynchronously and pc_write_o=1; normal capture resumes on the first edge after release.
// 6. CNT_W=2 with 5 consecutive load-use pairs -> stall_cnt_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-bundle layout and MIPS opcode/funct constants.
package pipe_pkg;

    localparam int CTRL_W = 16;

    // Control bundle bit offsets, LSB first; bit 15 is spare and travels unchanged.
    localparam int CTRL_REGDST     = 0;   // [1:0]
    localparam int CTRL_REGWRITE   = 2;
    localparam int CTRL_MEMWRITE   = 3;
    localparam int CTRL_MEMREAD    = 4;
    localparam int CTRL_MEMTOREG   = 5;   // [6:5]
    localparam int CTRL_JUMP       = 7;   // [8:7]
    localparam int CTRL_BRANCHTYPE = 9;   // [10:9]
    localparam int CTRL_BRANCH     = 11;
    localparam int CTRL_ALUSRC     = 12;
    localparam int CTRL_ALUOP      = 13;  // [14:13]

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] FUNCT_JR = 6'h08;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary signals; master is the ID/control side, slave is the ID/EX register.
interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) ();
    logic                        flush_i;
    logic [pipe_pkg::CTRL_W-1:0] id_ctrl_i;
    logic [DATA_W-1:0]           id_pc4_i;
    logic [DATA_W-1:0]           id_rs_data_i;
    logic [DATA_W-1:0]           id_rt_data_i;
    logic [DATA_W-1:0]           id_imm_i;
    logic [REG_ADDR_W-1:0]       id_rs_i;
    logic [REG_ADDR_W-1:0]       id_rt_i;
    logic [REG_ADDR_W-1:0]       id_rd_i;
    logic [5:0]                  id_funct_i;

    logic [pipe_pkg::CTRL_W-1:0] ex_ctrl_o;
    logic [DATA_W-1:0]           ex_pc4_o;
    logic [DATA_W-1:0]           ex_rs_data_o;
    logic [DATA_W-1:0]           ex_rt_data_o;
    logic [DATA_W-1:0]           ex_imm_o;
    logic [REG_ADDR_W-1:0]       ex_rs_o;
    logic [REG_ADDR_W-1:0]       ex_rt_o;
    logic [REG_ADDR_W-1:0]       ex_rd_o;
    logic [5:0]                  ex_funct_o;
    logic                        ex_valid_o;
    logic                        pc_write_o;
    logic                        if_id_write_o;
    logic [CNT_W-1:0]            stall_cnt_o;

    modport master (
        output flush_i, id_ctrl_i, id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_funct_i,
        input  ex_ctrl_o, ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o, ex_funct_o, ex_valid_o,
               pc_write_o, if_id_write_o, stall_cnt_o
    );

    modport slave (
        input  flush_i, id_ctrl_i, id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_funct_i,
        output ex_ctrl_o, ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o, ex_funct_o, ex_valid_o,
               pc_write_o, if_id_write_o, stall_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect_unit.sv
// Combinational load-use hazard detection; a pending flush overrides the stall.
module hazard_detect_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  flush,
    output logic                  hazard,
    output logic                  pc_write,
    output logic                  if_id_write
);
    // Loads into $0 never produce a usable value, so they never stall.
    assign hazard = ex_valid & ex_memread & (ex_rt != '0)
                  & ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign pc_write    = ~(hazard & ~flush);
    assign if_id_write = ~(hazard & ~flush);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and a
// saturating bubble counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    id_ex_stage_if.slave bus
);
    logic hazard;

    hazard_detect_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .ex_valid    (bus.ex_valid_o),
        .ex_memread  (bus.ex_ctrl_o[CTRL_MEMREAD]),
        .ex_rt       (bus.ex_rt_o),
        .id_rs       (bus.id_rs_i),
        .id_rt       (bus.id_rt_i),
        .flush       (bus.flush_i),
        .hazard      (hazard),
        .pc_write    (bus.pc_write_o),
        .if_id_write (bus.if_id_write_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.ex_ctrl_o    <= '0;
            bus.ex_pc4_o     <= '0;
            bus.ex_rs_data_o <= '0;
            bus.ex_rt_data_o <= '0;
            bus.ex_imm_o     <= '0;
            bus.ex_rs_o      <= '0;
            bus.ex_rt_o      <= '0;
            bus.ex_rd_o      <= '0;
            bus.ex_funct_o   <= '0;
            bus.ex_valid_o   <= 1'b0;
            bus.stall_cnt_o  <= '0;
        end else if (bus.flush_i) begin
            // Data fields are left as they were; only control and valid are killed.
            bus.ex_ctrl_o  <= '0;
            bus.ex_valid_o <= 1'b0;
        end else if (hazard) begin
            bus.ex_ctrl_o  <= '0;
            bus.ex_valid_o <= 1'b0;
            if (bus.stall_cnt_o != {CNT_W{1'b1}})
                bus.stall_cnt_o <= bus.stall_cnt_o + CNT_W'(1);
        end else begin
            bus.ex_ctrl_o    <= bus.id_ctrl_i;
            bus.ex_pc4_o     <= bus.id_pc4_i;
            bus.ex_rs_data_o <= bus.id_rs_data_i;
            bus.ex_rt_data_o <= bus.id_rt_data_i;
            bus.ex_imm_o     <= bus.id_imm_i;
            bus.ex_rs_o      <= bus.id_rs_i;
            bus.ex_rt_o      <= bus.id_rt_i;
            bus.ex_rd_o      <= bus.id_rd_i;
            bus.ex_funct_o   <= bus.id_funct_i;
            bus.ex_valid_o   <= 1'b1;
        end
    end
endmodule
